// File: rtl/bus_pkg.sv
// Shared constants for the femtorv32 bus controller:
// chip-select bit indices, IO page codes and FSM state encoding.
package bus_pkg;

  localparam int CS_DPRAM   = 6;
  localparam int CS_UART    = 5;
  localparam int CS_GPIO    = 4;
  localparam int CS_MULT    = 3;
  localparam int CS_DIV     = 2;
  localparam int CS_BIN2BCD = 1;
  localparam int CS_RAM     = 0;

  localparam logic [2:0] PG_DPRAM   = 3'd0;
  localparam logic [2:0] PG_UART    = 3'd1;
  localparam logic [2:0] PG_GPIO    = 3'd2;
  localparam logic [2:0] PG_MULT    = 3'd3;
  localparam logic [2:0] PG_DIV     = 3'd4;
  localparam logic [2:0] PG_BIN2BCD = 3'd5;

  typedef logic [6:0] cs_t;

  localparam cs_t CS_NONE = 7'b0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/bus_ctrl_if.sv
// Core/peripheral side bundle of the bus controller.
// master = core + slaves driving requests/ready; slave = controller.
interface bus_ctrl_if;

  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [3:0]  mem_wmask;
  logic [6:0]  slave_ready;
  logic [6:0]  cs;
  logic        rd_stb;
  logic        wr_stb;
  logic        mem_rbusy;
  logic        mem_wbusy;
  logic        bus_err;

  modport master (
    output mem_addr, mem_rstrb, mem_wmask,
    output slave_ready,
    input  cs, rd_stb, wr_stb,
    input  mem_rbusy, mem_wbusy, bus_err
  );

  modport slave (
    input  mem_addr, mem_rstrb, mem_wmask,
    input  slave_ready,
    output cs, rd_stb, wr_stb,
    output mem_rbusy, mem_wbusy, bus_err
  );

endinterface

// File: rtl/bus_addr_decode.sv
// Combinational address -> one-hot chip select.
// RAM when the IO bit is clear; IO pages 6 and 7 are unmapped.
module bus_addr_decode
  import bus_pkg::*;
#(
  parameter int IO_BIT   = 22,
  parameter int PAGE_LSB = 8
) (
  input  logic [31:0] addr,
  output cs_t         cs
);

  logic [2:0] page;
  logic       unused_addr;

  assign page        = addr[PAGE_LSB +: 3];
  assign unused_addr = &{1'b0, addr};

  always_comb begin
    cs = CS_NONE;
    if (!addr[IO_BIT]) begin
      cs[CS_RAM] = 1'b1;
    end else begin
      case (page)
        PG_DPRAM:   cs[CS_DPRAM]   = 1'b1;
        PG_UART:    cs[CS_UART]    = 1'b1;
        PG_GPIO:    cs[CS_GPIO]    = 1'b1;
        PG_MULT:    cs[CS_MULT]    = 1'b1;
        PG_DIV:     cs[CS_DIV]     = 1'b1;
        PG_BIN2BCD: cs[CS_BIN2BCD] = 1'b1;
        default:    cs = CS_NONE;
      endcase
    end
  end

endmodule

// File: rtl/bus_ctrl.sv
// femtorv32 bus controller: select hold, strobes, wait states, errors.
// Define BUS_TIMEOUT_EN to force-complete WAIT after TIMEOUT cycles.
module bus_ctrl
  import bus_pkg::*;
#(
  parameter int IO_BIT   = 22,
  parameter int PAGE_LSB = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  bus_ctrl_if.slave   bus
);

  state_t state_q, state_d;
  cs_t    cs_q, cs_d;
  cs_t    dec;
  cs_t    cs_o;
  logic   kind_q, kind_d;
  logic   err_q, err_d;
  logic   req, is_wr, done;
  logic   rd_o, wr_o, rbusy_o, wbusy_o;

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TMO = 8'(TIMEOUT);
  logic [7:0] tmo_q, tmo_d;
`endif

  bus_addr_decode #(
    .IO_BIT   (IO_BIT),
    .PAGE_LSB (PAGE_LSB)
  ) u_dec (
    .addr (bus.mem_addr),
    .cs   (dec)
  );

  assign is_wr = |bus.mem_wmask;
  assign req   = bus.mem_rstrb | is_wr;
  assign done  = (|(cs_q & bus.slave_ready))
               | (cs_q == CS_NONE);

  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    kind_d  = kind_q;
    err_d   = err_q;
    cs_o    = CS_NONE;
    rd_o    = 1'b0;
    wr_o    = 1'b0;
    rbusy_o = 1'b0;
    wbusy_o = 1'b0;
`ifdef BUS_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        cs_o = req ? dec : CS_NONE;
        rd_o = bus.mem_rstrb & ~is_wr;
        wr_o = is_wr;
        if (req) begin
          cs_d    = dec;
          kind_d  = is_wr;
          state_d = WAIT;
`ifdef BUS_TIMEOUT_EN
          tmo_d   = 8'd0;
`endif
        end
      end
      WAIT: begin
        cs_o = cs_q;
        if (done) begin
          state_d = IDLE;
          if (cs_q == CS_NONE) err_d = 1'b1;
        end else begin
`ifdef BUS_TIMEOUT_EN
          // hung slave: mux falls back to its default pattern
          if (tmo_q == TMO) begin
            cs_o    = CS_NONE;
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            rbusy_o = ~kind_q;
            wbusy_o = kind_q;
            tmo_d   = tmo_q + 8'd1;
          end
`else
          rbusy_o = ~kind_q;
          wbusy_o = kind_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cs_q    <= CS_NONE;
      kind_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      kind_q  <= kind_d;
      err_q   <= err_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= 8'd0;
    else     tmo_q <= tmo_d;
  end
`endif

  // keep the core and slaves quiet for the whole reset window
  assign bus.cs        = rst ? CS_NONE : cs_o;
  assign bus.rd_stb    = ~rst & rd_o;
  assign bus.wr_stb    = ~rst & wr_o;
  assign bus.mem_rbusy = ~rst & rbusy_o;
  assign bus.mem_wbusy = ~rst & wbusy_o;
  assign bus.bus_err   = err_q;

endmodule

// File: tb/tb_bus_ctrl.sv
// Randomized bench for bus_ctrl against a transaction-level model.
// Honours BUS_TIMEOUT_EN (runs with TIMEOUT=4 when defined).
module tb_bus_ctrl;

`ifdef BUS_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_ctrl_if bif ();

  bus_ctrl #(
    .IO_BIT   (22),
    .PAGE_LSB (8),
    .TIMEOUT  (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int   total = 0;
  int   bad   = 0;
  logic err_exp = 1'b0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_cs(logic [31:0] a);
    int pg;
    pg = int'(a[10:8]);
    if (!a[22]) return 7'd1;
    if (pg > 5) return 7'd0;
    return 7'(1 << (6 - pg));
  endfunction

  task automatic idle_cycle();
    @(negedge clk);
    bif.mem_rstrb   = 1'b0;
    bif.mem_wmask   = 4'd0;
    bif.mem_addr    = $urandom;
    bif.slave_ready = 7'($urandom);
    #1;
    check("idle_cs", 32'(bif.cs), 0);
    check("idle_out", {bif.rd_stb, bif.wr_stb,
          bif.mem_rbusy, bif.mem_wbusy}, 0);
    check("idle_err", 32'(bif.bus_err), 32'(err_exp));
  endtask

  // d: WAIT cycle index at which the selected ready rises
  // abort_at: WAIT cycle index to hit with reset (-1 = none)
  task automatic txn(logic [31:0] a, logic [3:0] wm, logic rs,
                     int d, int abort_at);
    logic [6:0] ec;
    logic       w, dn, tmo;
    bit         fin;
    ec  = ref_cs(a);
    w   = (wm != 4'd0);
    fin = 0;
    @(negedge clk);
    bif.mem_addr    = a;
    bif.mem_rstrb   = rs;
    bif.mem_wmask   = wm;
    bif.slave_ready = 7'($urandom);
    #1;
    check("req_cs", 32'(bif.cs), 32'(ec));
    check("req_rd", 32'(bif.rd_stb), 32'(rs & ~w));
    check("req_wr", 32'(bif.wr_stb), 32'(w));
    check("req_busy", {bif.mem_rbusy, bif.mem_wbusy}, 0);
    for (int k = 0; k <= TMO + 1 && !fin; k++) begin
      @(negedge clk);
      bif.mem_rstrb   = 1'b0;
      bif.mem_wmask   = 4'd0;
      bif.mem_addr    = $urandom;
      bif.slave_ready = (7'($urandom) & ~ec)
                      | ((k >= d) ? ec : 7'd0);
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        err_exp = 1'b0;
        check("abort_cs", 32'(bif.cs), 0);
        check("abort_out", {bif.rd_stb, bif.wr_stb,
              bif.mem_rbusy, bif.mem_wbusy}, 0);
        check("abort_err", 32'(bif.bus_err), 0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      #1;
      dn  = (ec == 7'd0) || (k >= d);
      tmo = !dn && (k == TMO);
      check("wait_cs", 32'(bif.cs), tmo ? 0 : 32'(ec));
      check("wait_stb", {bif.rd_stb, bif.wr_stb}, 0);
      check("wait_rbusy", 32'(bif.mem_rbusy),
            32'(!dn && !tmo && !w));
      check("wait_wbusy", 32'(bif.mem_wbusy),
            32'(!dn && !tmo && w));
      check("wait_err", 32'(bif.bus_err), 32'(err_exp));
      if (dn || tmo) begin
        fin = 1;
        if (ec == 7'd0 || tmo) err_exp = 1'b1;
      end
    end
    check("txn_bound", 32'(fin), 1);
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  wm;
    logic        rs;
    rst             = 1'b1;
    bif.mem_addr    = 32'h0000_0010;
    bif.mem_rstrb   = 1'b1;
    bif.mem_wmask   = 4'hf;
    bif.slave_ready = 7'h7f;
    #12;
    check("rst_cs", 32'(bif.cs), 0);
    check("rst_out", {bif.rd_stb, bif.wr_stb,
          bif.mem_rbusy, bif.mem_wbusy}, 0);
    check("rst_err", 32'(bif.bus_err), 0);
    @(negedge clk);
    bif.mem_rstrb = 1'b0;
    bif.mem_wmask = 4'd0;
    rst = 1'b0;
    idle_cycle();

    txn(32'h0000_0010, 4'h0, 1'b1, 0, -1);
    idle_cycle();
    txn(32'h0040_0300, 4'h0, 1'b1, 5, -1);
    txn(32'h0040_0100, 4'hf, 1'b0, 2, -1);
    txn(32'h0040_0700, 4'h0, 1'b1, 0, -1);
    idle_cycle();
    idle_cycle();
`ifdef BUS_TIMEOUT_EN
    txn(32'h0040_0400, 4'h0, 1'b1, 100, -1);
    idle_cycle();
`endif
    txn(32'h0040_0200, 4'h0, 1'b1, 10, 1);
    idle_cycle();
    txn(32'h0040_0200, 4'h0, 1'b1, 1, -1);
    txn(32'h0040_0600, 4'h3, 1'b1, 0, -1);
    rst = 1'b1;
    #1;
    err_exp = 1'b0;
    check("rst2_err", 32'(bif.bus_err), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 200; i++) begin
      a      = $urandom;
      a[22]  = ($urandom_range(0, 3) != 0);
      a[10:8] = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        wm = 4'($urandom_range(1, 15));
        rs = 1'($urandom_range(0, 1));
      end else begin
        wm = 4'd0;
        rs = 1'b1;
      end
      txn(a, wm, rs, $urandom_range(0, 7), -1);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
